// File: rtl/reset_watchdog_seq.sv
// Reset sequencer with staggered channel release and a run watchdog.
// Holds all reset channels, releases them one by one, then watches the core
// for heartbeat (kick) and completion (halt) while counting run cycles.
module reset_watchdog_seq #(
  parameter int unsigned      CHANNELS     = 4,
  parameter int unsigned      HOLD_CYCLES  = 25,
  parameter int unsigned      STAGGER      = 4,
  parameter int unsigned      WDT_WIDTH    = 32,
  parameter longint unsigned  WDT_LIMIT    = 150000000,
  parameter bit               AUTO_RESTART = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 kick,
  input  logic                 halt,
  input  logic                 wdt_en,
  output logic [CHANNELS-1:0]  rst_out,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [WDT_WIDTH-1:0] cycle_cnt,
  output logic [7:0]           restarts
);

  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned StagW  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam bit          Direct = (STAGGER == 0) || (CHANNELS == 1);

  localparam logic [HoldW-1:0]     HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [StagW-1:0]     StagLast = StagW'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [WDT_WIDTH-1:0] Limit    = WDT_WIDTH'(WDT_LIMIT);
  // Only the highest channel still asserted: the next release enters RUN.
  localparam logic [CHANNELS-1:0]  LastOnly = CHANNELS'(1) << (CHANNELS - 1);
  localparam logic [CHANNELS-1:0]  AllOnes  = {CHANNELS{1'b1}};

  typedef enum logic [2:0] {
    StHold,
    StRelease,
    StRun,
    StDone,
    StTimeout
  } state_e;

  state_e               state_q, state_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic [StagW-1:0]     stag_q, stag_d;
  logic [WDT_WIDTH-1:0] idle_q, idle_d;
  logic [WDT_WIDTH-1:0] idle_inc;
  logic [CHANNELS-1:0]  rst_out_q, rst_out_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [WDT_WIDTH-1:0] cycle_q, cycle_d;
  logic [7:0]           restarts_q, restarts_d;

  assign idle_inc = idle_q + WDT_WIDTH'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stag_d     = stag_q;
    idle_d     = idle_q;
    rst_out_d  = rst_out_q;
    running_d  = running_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    cycle_d    = cycle_q;
    restarts_d = restarts_q;

    unique case (state_q)
      StHold: begin
        rst_out_d = AllOnes;
        if (hold_q == HoldLast) begin
          hold_d = '0;
          stag_d = '0;
          if (Direct) begin
            rst_out_d = '0;
            running_d = 1'b1;
            state_d   = StRun;
          end else begin
            // Channel 0 releases on the same edge that leaves HOLD.
            rst_out_d = AllOnes << 1;
            state_d   = StRelease;
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end

      StRelease: begin
        if (stag_q == StagLast) begin
          stag_d    = '0;
          rst_out_d = rst_out_q & (rst_out_q << 1);
          if (rst_out_q == LastOnly) begin
            running_d = 1'b1;
            state_d   = StRun;
          end
        end else begin
          stag_d = stag_q + StagW'(1);
        end
      end

      StRun: begin
        if (cycle_q != {WDT_WIDTH{1'b1}}) begin
          cycle_d = cycle_q + WDT_WIDTH'(1);
        end
        if (kick || !wdt_en) begin
          idle_d = '0;
        end else begin
          idle_d = idle_inc;
        end
        // halt takes priority over a simultaneous watchdog expiry.
        if (halt) begin
          done_d    = 1'b1;
          running_d = 1'b0;
          state_d   = StDone;
        end else if (wdt_en && !kick && (idle_inc == Limit)) begin
          timeout_d = 1'b1;
          running_d = 1'b0;
          rst_out_d = AllOnes;
          state_d   = StTimeout;
        end
      end

      StDone: begin
        state_d = StDone;
      end

      StTimeout: begin
        rst_out_d = AllOnes;
        if (AUTO_RESTART) begin
          hold_d  = '0;
          idle_d  = '0;
          cycle_d = '0;
          if (restarts_q != 8'hFF) begin
            restarts_d = restarts_q + 8'd1;
          end
          state_d = StHold;
        end
      end

      default: begin
        state_d = StHold;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHold;
      hold_q     <= '0;
      stag_q     <= '0;
      idle_q     <= '0;
      rst_out_q  <= AllOnes;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cycle_q    <= '0;
      restarts_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      stag_q     <= stag_d;
      idle_q     <= idle_d;
      rst_out_q  <= rst_out_d;
      running_q  <= running_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      cycle_q    <= cycle_d;
      restarts_q <= restarts_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign running   = running_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_q;
  assign restarts  = restarts_q;

endmodule

// File: tb/tb_reset_watchdog_seq.sv
// Bench for reset_watchdog_seq: four differently configured instances share
// one clock; each is exercised in turn from a vector table and short sequences.
module tb_reset_watchdog_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v  = 4'hF;
  logic [3:0] kick_v = 4'h0;
  logic [3:0] halt_v = 4'h0;
  logic [3:0] wen_v  = 4'hF;

  // Instance 0: defaults
  logic [3:0]  d0_ro;
  logic        d0_run, d0_dn, d0_to;
  logic [31:0] d0_cc;
  logic [7:0]  d0_rs;
  // Instance 1: CHANNELS=2, HOLD=3, STAGGER=0
  logic [1:0]  d1_ro;
  logic        d1_run, d1_dn, d1_to;
  logic [31:0] d1_cc;
  logic [7:0]  d1_rs;
  // Instance 2: CHANNELS=2, HOLD=3, STAGGER=1, WDT_LIMIT=10
  logic [1:0]  d2_ro;
  logic        d2_run, d2_dn, d2_to;
  logic [31:0] d2_cc;
  logic [7:0]  d2_rs;
  // Instance 3: same as 2 but WDT_LIMIT=5, AUTO_RESTART=1
  logic [1:0]  d3_ro;
  logic        d3_run, d3_dn, d3_to;
  logic [31:0] d3_cc;
  logic [7:0]  d3_rs;

  reset_watchdog_seq u_def (
    .clk(clk), .rst(rst_v[0]), .kick(kick_v[0]), .halt(halt_v[0]), .wdt_en(wen_v[0]),
    .rst_out(d0_ro), .running(d0_run), .done(d0_dn), .timeout(d0_to),
    .cycle_cnt(d0_cc), .restarts(d0_rs)
  );

  reset_watchdog_seq #(.CHANNELS(2), .HOLD_CYCLES(3), .STAGGER(0)) u_s0 (
    .clk(clk), .rst(rst_v[1]), .kick(kick_v[1]), .halt(halt_v[1]), .wdt_en(wen_v[1]),
    .rst_out(d1_ro), .running(d1_run), .done(d1_dn), .timeout(d1_to),
    .cycle_cnt(d1_cc), .restarts(d1_rs)
  );

  reset_watchdog_seq #(.CHANNELS(2), .HOLD_CYCLES(3), .STAGGER(1), .WDT_LIMIT(10)) u_wdt (
    .clk(clk), .rst(rst_v[2]), .kick(kick_v[2]), .halt(halt_v[2]), .wdt_en(wen_v[2]),
    .rst_out(d2_ro), .running(d2_run), .done(d2_dn), .timeout(d2_to),
    .cycle_cnt(d2_cc), .restarts(d2_rs)
  );

  reset_watchdog_seq #(.CHANNELS(2), .HOLD_CYCLES(3), .STAGGER(1), .WDT_LIMIT(5),
                       .AUTO_RESTART(1'b1)) u_ar (
    .clk(clk), .rst(rst_v[3]), .kick(kick_v[3]), .halt(halt_v[3]), .wdt_en(wen_v[3]),
    .rst_out(d3_ro), .running(d3_run), .done(d3_dn), .timeout(d3_to),
    .cycle_cnt(d3_cc), .restarts(d3_rs)
  );

  typedef struct {
    int          dut;
    int          at;
    logic [3:0]  ro;
    logic        run;
    logic        dn;
    logic        to;
    logic [31:0] cc;
    logic [7:0]  rs;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   edge_n = 0;

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check(input string name, input logic [46:0] act, input logic [46:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [46:0] obs(input int d);
    case (d)
      0:       return {d0_ro, d0_run, d0_dn, d0_to, d0_cc, d0_rs};
      1:       return {2'b00, d1_ro, d1_run, d1_dn, d1_to, d1_cc, d1_rs};
      2:       return {2'b00, d2_ro, d2_run, d2_dn, d2_to, d2_cc, d2_rs};
      default: return {2'b00, d3_ro, d3_run, d3_dn, d3_to, d3_cc, d3_rs};
    endcase
  endfunction

  function automatic logic [46:0] pack(input vec_t v);
    return {v.ro, v.run, v.dn, v.to, v.cc, v.rs};
  endfunction

  task automatic add(input int d, input int at, input logic [3:0] ro, input logic run,
                     input logic dn, input logic to, input logic [31:0] cc, input logic [7:0] rs);
    vec_t v;
    v.dut = d; v.at = at; v.ro = ro; v.run = run; v.dn = dn; v.to = to; v.cc = cc; v.rs = rs;
    tbl.push_back(v);
  endtask

  // Hold reset a few cycles, release; the next rising edge is edge 0.
  task automatic release_dut(input int d);
    rst_v[d] = 1'b1;
    repeat (3) step();
    rst_v[d] = 1'b0;
    edge_n = -1;
  endtask

  task automatic run_table(input int d);
    release_dut(d);
    foreach (tbl[i]) begin
      if (tbl[i].dut == d) begin
        while (edge_n < tbl[i].at) step();
        check($sformatf("tbl%0d_dut%0d_edge%0d", i, d, tbl[i].at), obs(d), pack(tbl[i]));
      end
    end
  endtask

  logic seen_to;

  initial begin
    // Defaults: staggered release 24/28/32/36
    add(0,  0, 4'b1111, 0, 0, 0, 0, 0);
    add(0, 23, 4'b1111, 0, 0, 0, 0, 0);
    add(0, 24, 4'b1110, 0, 0, 0, 0, 0);
    add(0, 27, 4'b1110, 0, 0, 0, 0, 0);
    add(0, 28, 4'b1100, 0, 0, 0, 0, 0);
    add(0, 31, 4'b1100, 0, 0, 0, 0, 0);
    add(0, 32, 4'b1000, 0, 0, 0, 0, 0);
    add(0, 35, 4'b1000, 0, 0, 0, 0, 0);
    add(0, 36, 4'b0000, 1, 0, 0, 0, 0);
    add(0, 40, 4'b0000, 1, 0, 0, 4, 0);
    // STAGGER=0: both channels clear together at edge 2
    add(1,  0, 4'b0011, 0, 0, 0, 0, 0);
    add(1,  1, 4'b0011, 0, 0, 0, 0, 0);
    add(1,  2, 4'b0000, 1, 0, 0, 0, 0);
    add(1,  5, 4'b0000, 1, 0, 0, 3, 0);
    // Auto-restart with WDT_LIMIT=5: period of 10 edges
    add(3,  2, 4'b0010, 0, 0, 0, 0, 0);
    add(3,  3, 4'b0000, 1, 0, 0, 0, 0);
    add(3,  7, 4'b0000, 1, 0, 0, 4, 0);
    add(3,  8, 4'b0011, 0, 0, 1, 5, 0);
    add(3,  9, 4'b0011, 0, 0, 1, 0, 1);
    add(3, 12, 4'b0010, 0, 0, 1, 0, 1);
    add(3, 13, 4'b0000, 1, 0, 1, 0, 1);
    add(3, 18, 4'b0011, 0, 0, 1, 5, 1);
    add(3, 19, 4'b0011, 0, 0, 1, 0, 2);
    add(3, 29, 4'b0011, 0, 0, 1, 0, 3);

    // Reset values of every instance
    repeat (3) step();
    check("reset_def", obs(0), {4'b1111, 43'd0});
    check("reset_s0",  obs(1), {4'b0011, 43'd0});
    check("reset_wdt", obs(2), {4'b0011, 43'd0});
    check("reset_ar",  obs(3), {4'b0011, 43'd0});

    run_table(0);
    run_table(1);
    run_table(3);

    // rst pulse clears restarts and timeout
    rst_v[3] = 1'b1;
    step();
    check("ar_rst_clear", obs(3), {4'b0011, 43'd0});
    // wdt_en=0 holds the idle counter; enabling it expires 5 edges later
    rst_v[3] = 1'b0;
    edge_n = -1;
    wen_v[3] = 1'b0;
    while (edge_n < 25) step();
    check("ar_wdt_off", {d3_run, d3_to}, 2'b10);
    wen_v[3] = 1'b1;
    while (edge_n < 29) step();
    check("ar_wdt_on_pre", {d3_run, d3_to}, 2'b10);
    step();
    check("ar_wdt_on_exp", {d3_run, d3_to, d3_rs}, {2'b01, 8'd0});

    // rst mid-RELEASE returns to HOLD, then timing restarts from edge 0
    release_dut(0);
    while (edge_n < 29) step();
    check("mid_rel_state", {28'd0, d0_ro}, 32'b1100);
    rst_v[0] = 1'b1;
    step();
    check("mid_rel_rst", obs(0), {4'b1111, 43'd0});
    rst_v[0] = 1'b0;
    edge_n = -1;
    while (edge_n < 23) step();
    check("mid_rel_e23", {d0_ro, d0_run}, 5'b11110);
    step();
    check("mid_rel_e24", {d0_ro, d0_run}, 5'b11100);
    while (edge_n < 36) step();
    check("mid_rel_e36", {d0_ro, d0_run}, 5'b00001);

    // Kicks every 5 cycles keep the watchdog quiet; stopping expires it
    release_dut(2);
    while (edge_n < 3) step();
    check("wdt_run", {d2_ro, d2_run}, 3'b001);
    seen_to = 1'b0;
    for (int i = 0; i < 100; i++) begin
      kick_v[2] = (i % 5 == 4);
      step();
      seen_to |= d2_to;
    end
    kick_v[2] = 1'b0;
    check("wdt_kicked_no_to", {seen_to, d2_run}, 2'b01);
    // Last kick sampled at edge 103
    repeat (9) step();
    check("wdt_e112", {d2_run, d2_to}, 2'b10);
    step();
    check("wdt_e113_to", {d2_ro, d2_run, d2_to}, 4'b1101);
    check("wdt_e113_cc", d2_cc, 32'd110);

    // halt and idle limit on the same edge: halt wins
    release_dut(2);
    while (edge_n < 12) step();
    check("hw_e12", {d2_run, d2_dn, d2_to}, 3'b100);
    halt_v[2] = 1'b1;
    step();
    halt_v[2] = 1'b0;
    check("hw_e13", {d2_ro, d2_run, d2_dn, d2_to, d2_cc}, {2'b00, 3'b010, 32'd10});
    kick_v[2] = 1'b1;
    repeat (5) step();
    kick_v[2] = 1'b0;
    check("hw_frozen", {d2_ro, d2_run, d2_dn, d2_to, d2_cc}, {2'b00, 3'b010, 32'd10});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog on the bench itself
  initial begin
    #500000;
    $display("FAIL bench_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/reset_watchdog_seq.md
# reset_watchdog_seq

Parametrised reset sequencer and run watchdog that supersedes the fixed hold-then-release reset in the CPU simulation harness. It holds a configurable number of reset channels for a set number of cycles, then releases them in a staggered order. It monitors the running core for a heartbeat and a halt indication, and flags timeout or completion. It sits between the board/bench reset source and `riscv_top`, memory controller and IO domains, and is synthesizable for both simulation and FPGA builds.

## Interface
Parameters:
- CHANNELS, 4, number of reset outputs (≥1)
- HOLD_CYCLES, 25, cycles all channels stay asserted after `rst` is sampled low (≥1)
- STAGGER, 4, cycles between successive channel releases (0 = release all together)
- WDT_WIDTH, 32, width of the watchdog and cycle counters
- WDT_LIMIT, 150000000, idle cycles without `kick` before timeout (≥1, < 2^WDT_WIDTH)
- AUTO_RESTART, 0, 1 = on timeout, re-run the reset sequence; 0 = latch in TIMEOUT

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- kick  in  1  heartbeat from the core; clears the idle counter
- halt  in  1  program finished; ends the run
- wdt_en  in  1  watchdog enable; when 0 the idle counter holds at 0
- rst_out  out  CHANNELS  per-channel active-high reset, bit 0 released first
- running  out  1  high while in RUN
- done  out  1  sticky, halt seen in RUN
- timeout  out  1  sticky, watchdog expired
- cycle_cnt  out  WDT_WIDTH  cycles spent in RUN, saturating
- restarts  out  8  number of auto-restarts, saturating at 255

## Operation
- States: HOLD, RELEASE, RUN, DONE, TIMEOUT. Every output is registered.
- While `rst` = 1:
  - state is HOLD and all counters are 0.
  - `rst_out` is all ones.
  - `running`, `done`, `timeout`, `cycle_cnt` and `restarts` are all 0.
- HOLD: the hold counter increments each cycle. At the edge where it reaches HOLD_CYCLES, move to RELEASE and clear `rst_out[0]` on that same edge.
- RELEASE: `rst_out[i]` clears exactly i*STAGGER edges after `rst_out[0]` clears. On the edge where `rst_out[CHANNELS-1]` clears, move to RUN and set `running` to 1. With STAGGER = 0 or CHANNELS = 1, HOLD goes straight to RUN and all bits clear on one edge.
- RUN:
  - `cycle_cnt` increments each cycle and saturates at all ones.
  - The idle counter increments each cycle when `wdt_en` = 1 and `kick` = 0. It resets to 0 when `kick` = 1 or `wdt_en` = 0.
  - `halt` = 1 moves to DONE.
  - Idle counter reaching WDT_LIMIT moves to TIMEOUT.
  - If both occur on the same edge, `halt` wins.
- DONE:
  - `done` = 1, `running` = 0, `rst_out` stays 0 and `cycle_cnt` freezes.
  - Stays in DONE until `rst`.
- TIMEOUT:
  - `timeout` = 1, `running` = 0, `rst_out` = all ones.
  - AUTO_RESTART = 0: stays in TIMEOUT until `rst`.
  - AUTO_RESTART = 1: the next edge enters HOLD with the hold counter, idle counter and `cycle_cnt` cleared, and `restarts` increments (saturating). `timeout` stays sticky.
- `kick` and `halt` are ignored outside RUN.
- `rst` asserted mid-sequence in any state returns to the reset values on the next edge, including clearing `restarts`.

## Timing
- Let edge 0 be the first rising edge with `rst` = 0.
  - `rst_out[0]` is 0 after edge HOLD_CYCLES-1.
  - `rst_out[i]` is 0 after edge HOLD_CYCLES-1+i*STAGGER.
  - `running` goes high on the same edge as the last channel release.
- Timeout: with `kick` = 0 and `wdt_en` = 1 from the first RUN cycle, `timeout` rises WDT_LIMIT edges after RUN entry.
- `halt` sampled high at edge n gives `done` = 1 and `running` = 0 after edge n (1-cycle latency).
- Auto-restart: the HOLD phase begins one edge after `timeout` rises, with `rst_out` continuously asserted in between.

## Test plan
- Defaults, `rst` high for 10 cycles, then low.
  - `rst_out` goes 1111 → 1110 at edge 24, 1100 at 28, 1000 at 32, 0000 at 36.
  - `running` = 1 at edge 36.
- STAGGER = 0, CHANNELS = 2, HOLD_CYCLES = 3.
  - Both bits clear together at edge 2 and `running` = 1 there.
- WDT_LIMIT = 10, `kick` pulsed every 5 cycles for 100 cycles → no timeout.
  - Stop kicking → `timeout` = 1 exactly 10 edges after the last kick.
  - `rst_out` = all ones after that.
- WDT_LIMIT = 10, `halt` and idle-limit on the same edge → `done` = 1, `timeout` = 0.
  - `cycle_cnt` then holds its value.
- AUTO_RESTART = 1, WDT_LIMIT = 5, no kicks.
  - The sequence repeats and `restarts` counts 1, 2, 3.
  - `timeout` stays 1.
  - `rst` pulse clears `restarts` and `timeout`.
- `rst` asserted mid-RELEASE (`rst_out` = 1100) → next edge `rst_out` = 1111 and state is HOLD.
  - Full sequence restarts from edge 0 timing.
